// File: rtl/home_ctrl_pkg.sv
// Shared types and helpers for the home-automation controller.
package home_ctrl_pkg;

   typedef enum logic [1:0] {
      LkLocked   = 2'd0,
      LkUnlocked = 2'd1,
      LkLockout  = 2'd2
   } lock_state_e;

   typedef enum logic [1:0] {
      ClOff = 2'd0,
      ClFan = 2'd1,
      ClAc  = 2'd2
   } climate_state_e;

   localparam logic [3:0] FAN_SPEED_MAX = 4'hF;

   // Threshold minus hysteresis, clamped at zero instead of wrapping.
   function automatic logic [4:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? ({1'b0, a} - {1'b0, b}) : 5'd0;
   endfunction

   // min(temp - thr + 1, 15), clamped at zero when temp sits below thr - 1.
   function automatic logic [3:0] fan_speed(input logic [3:0] temp, input logic [3:0] thr);
      logic [4:0] w_num;
      w_num = {1'b0, temp} + 5'd1;
      if (w_num <= {1'b0, thr}) return 4'd0;
      w_num = w_num - {1'b0, thr};
      return (w_num > {1'b0, FAN_SPEED_MAX}) ? FAN_SPEED_MAX : w_num[3:0];
   endfunction

endpackage

// File: rtl/home_climate_fsm.sv
// Climate scheduler: mutually exclusive FAN/AC modes with hysteresis and a minimum hold time.
module home_climate_fsm
   import home_ctrl_pkg::*;
#(
   parameter int unsigned MIN_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_enable,
   input  logic [3:0] i_temp,
   input  logic [3:0] i_temp_fan,
   input  logic [3:0] i_temp_ac,
   input  logic [3:0] i_hyst,
   output logic       o_fan_en,
   output logic       o_ac_en,
   output logic       o_wind_en,
   output logic [3:0] o_fan_out
);

   localparam int unsigned HW = $clog2(MIN_HOLD + 1);

   climate_state_e r_state, w_state_d, w_mode_req;
   logic [HW-1:0]  r_hold, w_hold_d;
   logic [4:0]     w_temp5, w_fan_exit, w_ac_exit;
   logic           w_fan_en_d, w_ac_en_d, w_wind_en_d;
   logic [3:0]     w_fan_out_d;

   assign w_temp5    = {1'b0, i_temp};
   assign w_fan_exit = sat_sub(i_temp_fan, i_hyst);
   assign w_ac_exit  = sat_sub(i_temp_ac, i_hyst);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ClOff;
         r_hold    <= '0;
         o_fan_en  <= 1'b0;
         o_ac_en   <= 1'b0;
         o_wind_en <= 1'b0;
         o_fan_out <= 4'd0;
      end else begin
         r_state   <= w_state_d;
         r_hold    <= w_hold_d;
         o_fan_en  <= w_fan_en_d;
         o_ac_en   <= w_ac_en_d;
         o_wind_en <= w_wind_en_d;
         o_fan_out <= w_fan_out_d;
      end
   end

   always_comb begin
      w_mode_req = r_state;
      unique case (r_state)
         ClOff: begin
            if (w_temp5 >= {1'b0, i_temp_ac})       w_mode_req = ClAc;
            else if (w_temp5 >= {1'b0, i_temp_fan}) w_mode_req = ClFan;
         end
         ClFan: begin
            if (w_temp5 >= {1'b0, i_temp_ac}) w_mode_req = ClAc;
            else if (w_temp5 < w_fan_exit)    w_mode_req = ClOff;
         end
         ClAc: begin
            if (w_temp5 < w_ac_exit)
               w_mode_req = (w_temp5 >= {1'b0, i_temp_fan}) ? ClFan : ClOff;
         end
         default: w_mode_req = ClOff;
      endcase

      w_state_d = r_state;
      w_hold_d  = r_hold;
      if (!i_enable) begin
         w_state_d = ClOff;
         w_hold_d  = '0;
      end else if (r_hold != '0) begin
         w_hold_d = r_hold - HW'(1);
      end else if (w_mode_req != r_state) begin
         w_state_d = w_mode_req;
         w_hold_d  = HW'(MIN_HOLD - 1);
      end
   end

   // Outputs follow the next state so they change on the same edge as the mode.
   always_comb begin
      w_fan_en_d  = (w_state_d == ClFan);
      w_ac_en_d   = (w_state_d == ClAc);
      w_wind_en_d = (w_state_d == ClFan);
      w_fan_out_d = 4'd0;
      if (w_state_d == ClFan)     w_fan_out_d = fan_speed(i_temp, i_temp_fan);
      else if (w_state_d == ClAc) w_fan_out_d = 4'd1;
   end

endmodule

// File: rtl/home_ctrl_sequencer.sv
// Door lock sequencer, light gating and climate control top.
// Optional HOME_CTRL_ALARM_EN adds an alarm output that blinks during lockout.
module home_ctrl_sequencer
   import home_ctrl_pkg::*;
#(
   parameter logic [3:0]  PASS_CODE   = 4'b0110,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCKOUT_CYC = 16,
   parameter logic [3:0]  TEMP_FAN    = 4'd8,
   parameter logic [3:0]  TEMP_AC     = 4'd11,
   parameter logic [3:0]  HYST        = 4'd1,
   parameter int unsigned MIN_HOLD    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pa_valid,
   input  logic [3:0] pa,
   input  logic       relock,
   input  logic [3:0] light_req,
   input  logic [3:0] temp,
   output logic       lock_out,
   output logic       lockout_active,
   output logic [1:0] fail_cnt,
   output logic [3:0] light_out,
   output logic       fan_en,
   output logic       ac_en,
   output logic       wind_en,
   output logic [3:0] fan_out
`ifdef HOME_CTRL_ALARM_EN
   ,
   output logic       alarm
`endif
);

   localparam int unsigned TW = $clog2(LOCKOUT_CYC);

   lock_state_e   r_state, w_state_d;
   logic [1:0]    r_fail_cnt, w_fail_cnt_d, w_fail_inc;
   logic [TW-1:0] r_timer, w_timer_d;
   logic          r_lock_out, r_lockout_active;
   logic [3:0]    r_light;
   logic          w_lock_out_d, w_lockout_active_d;
   logic [3:0]    w_light_d;
   logic          w_unlocked_d;

   assign w_fail_inc = r_fail_cnt + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= LkLocked;
         r_fail_cnt       <= 2'd0;
         r_timer          <= '0;
         r_lock_out       <= 1'b0;
         r_lockout_active <= 1'b0;
         r_light          <= 4'd0;
      end else begin
         r_state          <= w_state_d;
         r_fail_cnt       <= w_fail_cnt_d;
         r_timer          <= w_timer_d;
         r_lock_out       <= w_lock_out_d;
         r_lockout_active <= w_lockout_active_d;
         r_light          <= w_light_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_fail_cnt_d = r_fail_cnt;
      w_timer_d    = r_timer;
      unique case (r_state)
         LkLocked: begin
            if (pa_valid) begin
               if (pa == PASS_CODE) begin
                  w_state_d    = LkUnlocked;
                  w_fail_cnt_d = 2'd0;
               end else begin
                  w_fail_cnt_d = w_fail_inc;
                  if (w_fail_inc == 2'(MAX_TRIES)) begin
                     w_state_d = LkLockout;
                     w_timer_d = TW'(LOCKOUT_CYC - 1);
                  end
               end
            end
         end
         // relock wins over a simultaneous attempt because attempts are ignored here anyway.
         LkUnlocked: begin
            if (relock) w_state_d = LkLocked;
         end
         LkLockout: begin
            if (r_timer == '0) begin
               w_state_d    = LkLocked;
               w_fail_cnt_d = 2'd0;
            end else begin
               w_timer_d = r_timer - TW'(1);
            end
         end
         default: w_state_d = LkLocked;
      endcase
   end

   always_comb begin
      w_unlocked_d       = (w_state_d == LkUnlocked);
      w_lock_out_d       = w_unlocked_d;
      w_lockout_active_d = (w_state_d == LkLockout);
      w_light_d          = w_unlocked_d ? light_req : 4'd0;
   end

   assign lock_out       = r_lock_out;
   assign lockout_active = r_lockout_active;
   assign fail_cnt       = r_fail_cnt;
   assign light_out      = r_light;

   home_climate_fsm #(
      .MIN_HOLD (MIN_HOLD)
   ) u_climate (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (w_unlocked_d),
      .i_temp     (temp),
      .i_temp_fan (TEMP_FAN),
      .i_temp_ac  (TEMP_AC),
      .i_hyst     (HYST),
      .o_fan_en   (fan_en),
      .o_ac_en    (ac_en),
      .o_wind_en  (wind_en),
      .o_fan_out  (fan_out)
   );

`ifdef HOME_CTRL_ALARM_EN
   logic       r_alarm;
   logic [1:0] r_alarm_ph, w_alarm_ph_inc;

   assign w_alarm_ph_inc = r_alarm_ph + 2'd1;

   // Two cycles high, two low, starting high on the lockout entry edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alarm    <= 1'b0;
         r_alarm_ph <= 2'd0;
      end else if (w_state_d == LkLockout) begin
         if (r_state != LkLockout) begin
            r_alarm    <= 1'b1;
            r_alarm_ph <= 2'd0;
         end else begin
            r_alarm    <= ~w_alarm_ph_inc[1];
            r_alarm_ph <= w_alarm_ph_inc;
         end
      end else begin
         r_alarm    <= 1'b0;
         r_alarm_ph <= 2'd0;
      end
   end

   assign alarm = r_alarm;
`endif

endmodule
